// File: rtl/synth_pkg.sv
// Shared constants, types and voice waveform helper for the audio synth.
package synth_pkg;

  localparam int          SAMPLE_WIDTH = 24;
  localparam logic [31:0] DEFAULT_FREQ = 32'h024E8ED9;
  localparam int          NUM_VOICES   = 3;
  localparam int          MIX_W        = SAMPLE_WIDTH + 2;

  localparam int CNT_W     = 11;
  localparam int SYS_BIT   = 2;
  localparam int BCLK_BIT  = 4;
  localparam int LR_BIT    = 10;

  typedef enum logic [1:0] {
    SAWTOOTH,
    SQUARE,
    TRIANGLE
  } shape_t;

  typedef logic signed [SAMPLE_WIDTH-1:0] sample_t;

  localparam sample_t SQ_MAX =
    sample_t'((1 << (SAMPLE_WIDTH - 1)) - 1);

  function automatic sample_t voice(
    input shape_t      shape,
    input logic [31:0] phase
  );
    sample_t p;
    sample_t t;
    sample_t v;
    p = phase[31 -: SAMPLE_WIDTH];
    t = phase[31] ? ~(p << 1) : (p << 1);
    t[SAMPLE_WIDTH-1] = ~t[SAMPLE_WIDTH-1];
    v = '0;
    case (shape)
      SAWTOOTH: v = p;
      SQUARE:   v = phase[31] ? -SQ_MAX : SQ_MAX;
      TRIANGLE: v = t;
      default:  v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/synth_i2s_tx.sv
// I2S transmitter: divides MASTER_CLK into DAC clocks and serialises
// one mono sample per frame (left and right), emitting the sample tick.
module i2s_tx
  import synth_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  sample_t sample,
  output logic    tick,
  output logic    sys_clk,
  output logic    bit_clk,
  output logic    lr_clk,
  output logic    data
);

  logic [CNT_W-1:0] cnt;
  sample_t          hold;
  logic [31:0]      word;
  logic [4:0]       bit_idx;

  assign word    = {{(32-SAMPLE_WIDTH){hold[SAMPLE_WIDTH-1]}}, hold};
  assign bit_idx = ~cnt[LR_BIT-1:BCLK_BIT+1];
  assign tick    = ~rst & (cnt == '0);

  // Outputs are registered from cnt, so they lag it by one cycle;
  // hold is refreshed on the last cycle so left bit 0 sees the new word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      hold    <= '0;
      sys_clk <= 1'b0;
      bit_clk <= 1'b0;
      lr_clk  <= 1'b0;
      data    <= 1'b0;
    end else begin
      cnt     <= cnt + CNT_W'(1);
      if (&cnt)
        hold  <= sample;
      sys_clk <= cnt[SYS_BIT];
      bit_clk <= cnt[BCLK_BIT];
      lr_clk  <= ~cnt[LR_BIT];
      data    <= word[bit_idx];
    end
  end

endmodule

// File: rtl/synth_top.sv
// Audio synth top: three gated tone voices, mono mixer, I2S DAC output.
// Define SPI_CTRL_EN to retune the voices over the SPI slave.
module synth_top
  import synth_pkg::*;
(
  input  logic       MASTER_CLK,
  input  logic       rst,
  input  logic       spi_clk,
  input  logic       spi_cs,
  input  logic       spi_mosi,
  output logic       spi_miso,
  input  logic [7:0] gpio,
  output logic       dac_sys_clk,
  output logic       dac_bit_clk,
  output logic       dac_lr_clk,
  output logic       dac_data
);

  logic [31:0]             freq;
  logic [31:0]             phase [NUM_VOICES];
  sample_t                 voice_out [NUM_VOICES];
  logic signed [MIX_W-1:0] mix_acc;
  sample_t                 mix;
  sample_t                 sample;
  logic                    tick;

  assign voice_out[0] = voice(SAWTOOTH, phase[0]);
  assign voice_out[1] = voice(SQUARE,   phase[1]);
  assign voice_out[2] = voice(TRIANGLE, phase[2]);

  always_comb begin
    mix_acc = '0;
    for (int k = 0; k < NUM_VOICES; k++)
      if (gpio[k])
        mix_acc = mix_acc + MIX_W'(voice_out[k] >>> 2);
    mix = mix_acc[SAMPLE_WIDTH-1:0];
  end

  always_ff @(posedge MASTER_CLK or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_VOICES; k++)
        phase[k] <= '0;
      sample <= '0;
    end else if (tick) begin
      for (int k = 0; k < NUM_VOICES; k++)
        phase[k] <= phase[k] + freq;
      sample <= mix;
    end
  end

  i2s_tx u_i2s (
    .clk     (MASTER_CLK),
    .rst     (rst),
    .sample  (sample),
    .tick    (tick),
    .sys_clk (dac_sys_clk),
    .bit_clk (dac_bit_clk),
    .lr_clk  (dac_lr_clk),
    .data    (dac_data)
  );

`ifdef SPI_CTRL_EN
  logic [2:0]  sclk_s;
  logic [2:0]  cs_s;
  logic [1:0]  mosi_s;
  logic [2:0]  bit_cnt;
  logic [1:0]  byte_cnt;
  logic [7:0]  shreg;
  logic [7:0]  last;
  logic [7:0]  rx_byte;
  logic [23:0] rx_word;
  logic [31:0] new_freq;
  logic        pending;
  logic        cs_n;
  logic        cs_fall;
  logic        sclk_rise;
  logic        sclk_fall;
  logic        unused;

  assign cs_n      = cs_s[1];
  assign cs_fall   = ~cs_s[1] & cs_s[2];
  assign sclk_rise = sclk_s[1] & ~sclk_s[2];
  assign sclk_fall = ~sclk_s[1] & sclk_s[2];
  assign rx_byte   = {mosi_s[1], shreg[7:1]};
  assign unused    = ^{gpio[7:3], mix_acc[MIX_W-1:SAMPLE_WIDTH]};

  // A new word waits in new_freq until the next tick so a frame
  // never mixes two pitches.
  always_ff @(posedge MASTER_CLK or posedge rst) begin
    if (rst) begin
      sclk_s   <= '0;
      cs_s     <= '1;
      mosi_s   <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      shreg    <= '0;
      last     <= '0;
      rx_word  <= '0;
      new_freq <= DEFAULT_FREQ;
      pending  <= 1'b0;
      freq     <= DEFAULT_FREQ;
      spi_miso <= 1'b0;
    end else begin
      sclk_s <= {sclk_s[1:0], spi_clk};
      cs_s   <= {cs_s[1:0], spi_cs};
      mosi_s <= {mosi_s[0], spi_mosi};
      if (tick && pending) begin
        freq    <= new_freq;
        pending <= 1'b0;
      end
      if (cs_n) begin
        bit_cnt  <= '0;
        byte_cnt <= '0;
        spi_miso <= 1'b0;
      end else begin
        if (cs_fall)
          spi_miso <= last[0];
        if (sclk_fall)
          spi_miso <= last[bit_cnt];
        if (sclk_rise) begin
          shreg   <= rx_byte;
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            last     <= rx_byte;
            rx_word  <= {rx_byte, rx_word[23:8]};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              new_freq <= {rx_byte, rx_word};
              pending  <= 1'b1;
            end
          end
        end
      end
    end
  end
`else
  logic unused;

  assign freq     = DEFAULT_FREQ;
  assign spi_miso = 1'b0;
  assign unused   = ^{gpio[7:3], spi_clk, spi_cs, spi_mosi,
                      mix_acc[MIX_W-1:SAMPLE_WIDTH]};
`endif

endmodule

// File: tb/tb_synth_top.sv
// Directed self-checking bench for synth_top: decodes the I2S stream
// and compares captured frames against hand-computed sample words.
module tb_synth_top;

  localparam int CLK_HALF = 5;

  logic       MASTER_CLK = 1'b0;
  logic       rst        = 1'b1;
  logic       spi_clk    = 1'b0;
  logic       spi_cs     = 1'b1;
  logic       spi_mosi   = 1'b0;
  logic [7:0] gpio       = 8'h00;
  logic       spi_miso;
  logic       dac_sys_clk;
  logic       dac_bit_clk;
  logic       dac_lr_clk;
  logic       dac_data;

  int      checks = 0;
  int      errors = 0;
  realtime t_lr;

  always #CLK_HALF MASTER_CLK = ~MASTER_CLK;

  synth_top dut (
    .MASTER_CLK  (MASTER_CLK),
    .rst         (rst),
    .spi_clk     (spi_clk),
    .spi_cs      (spi_cs),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .gpio        (gpio),
    .dac_sys_clk (dac_sys_clk),
    .dac_bit_clk (dac_bit_clk),
    .dac_lr_clk  (dac_lr_clk),
    .dac_data    (dac_data)
  );

  // Waits for the next frame start, applies g, then decodes 64 bits.
  task automatic get_frame(input logic [7:0] g,
                           output logic [31:0] l,
                           output logic [31:0] r);
    int          n = 0;
    int          bits = 0;
    logic        pl;
    logic        pb;
    logic [63:0] w = '0;
    l = '0;
    r = '0;
    pl = dac_lr_clk;
    forever begin
      @(negedge MASTER_CLK);
      n++;
      if (!pl && dac_lr_clk) break;
      pl = dac_lr_clk;
      if (n > 4200) break;
    end
    if (n > 4200) begin
      checks++; errors++;
      $display("FAIL frame_start timeout got none want lr rise");
      return;
    end
    t_lr = $realtime;
    gpio = g;
    pb = dac_bit_clk;
    while (bits < 64 && n < 8400) begin
      @(negedge MASTER_CLK);
      n++;
      if (!pb && dac_bit_clk) begin
        w = {w[62:0], dac_data};
        bits++;
      end
      pb = dac_bit_clk;
    end
    if (bits < 64) begin
      checks++; errors++;
      $display("FAIL frame_bits got %0d want 64", bits);
    end
    l = w[63:32];
    r = w[31:0];
  endtask

  task automatic do_reset(input logic [7:0] g);
    @(negedge MASTER_CLK);
    rst = 1'b1;
    gpio = g;
    spi_cs = 1'b1;
    repeat (4) @(negedge MASTER_CLK);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] l, r;
    realtime     t0;
    t0 = 0;
    @(negedge MASTER_CLK);
    rst = 1'b1;
    gpio = 8'h00;
    repeat (3) @(negedge MASTER_CLK);
    checks++;
    if ({dac_sys_clk, dac_bit_clk, dac_lr_clk, dac_data, spi_miso} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b want 00000",
               {dac_sys_clk, dac_bit_clk, dac_lr_clk, dac_data, spi_miso});
    end
    rst = 1'b0;
    for (int f = 0; f < 3; f++) begin
      get_frame(8'h00, l, r);
      checks++;
      if (l !== 32'h0) begin
        errors++;
        $display("FAIL reset_left f%0d got %h want 0", f, l);
      end
      checks++;
      if (r !== 32'h0) begin
        errors++;
        $display("FAIL reset_right f%0d got %h want 0", f, r);
      end
      if (f == 1) t0 = t_lr;
      if (f == 2) begin
        checks++;
        if (t_lr - t0 != real'(4096 * CLK_HALF)) begin
          errors++;
          $display("FAIL lr_period got %0t want %0d", t_lr - t0, 4096 * CLK_HALF);
        end
      end
    end
  endtask

  task automatic test_sawtooth();
    logic [31:0] l, r;
    logic [31:0] e [4];
    e = '{32'h0, 32'h0, 32'h0000_93A3, 32'h0001_2747};
    do_reset(8'h01);
    for (int f = 0; f < 4; f++) begin
      get_frame(8'h01, l, r);
      checks++;
      if (l !== e[f]) begin
        errors++;
        $display("FAIL saw_left f%0d got %h want %h", f, l, e[f]);
      end
      checks++;
      if (r !== e[f]) begin
        errors++;
        $display("FAIL saw_right f%0d got %h want %h", f, r, e[f]);
      end
    end
  endtask

  task automatic test_square();
    logic [31:0] l, r;
    logic [31:0] e [3];
    e = '{32'h0, 32'h001F_FFFF, 32'h001F_FFFF};
    do_reset(8'h02);
    for (int f = 0; f < 3; f++) begin
      get_frame(8'h02, l, r);
      checks++;
      if (l !== e[f] || r !== e[f]) begin
        errors++;
        $display("FAIL square f%0d got %h/%h want %h", f, l, r, e[f]);
      end
    end
  endtask

  task automatic test_triangle();
    logic [31:0] l, r;
    logic [31:0] e [4];
    e = '{32'h0, 32'hFFE0_0000, 32'hFFE1_2747, 32'hFFE2_4E8E};
    do_reset(8'h04);
    for (int f = 0; f < 4; f++) begin
      get_frame(8'h04, l, r);
      checks++;
      if (l !== e[f] || r !== e[f]) begin
        errors++;
        $display("FAIL triangle f%0d got %h/%h want %h", f, l, r, e[f]);
      end
    end
  endtask

  task automatic test_all_voices();
    logic [31:0] l, r;
    logic [31:0] e [3];
    e = '{32'h0, 32'hFFFF_FFFF, 32'h0001_BAE9};
    do_reset(8'hFF);
    for (int f = 0; f < 3; f++) begin
      get_frame(8'hFF, l, r);
      checks++;
      if (l !== e[f] || r !== e[f]) begin
        errors++;
        $display("FAIL all_voices f%0d got %h/%h want %h", f, l, r, e[f]);
      end
    end
  endtask

  task automatic test_gate();
    logic [31:0] l, r;
    logic [7:0]  g [8];
    logic [31:0] e [8];
    g = '{8'h01, 8'h01, 8'h01, 8'h00, 8'h00, 8'h01, 8'h01, 8'h01};
    e = '{32'h0, 32'h0, 32'h0000_93A3, 32'h0001_2747,
          32'h0001_BAEB, 32'h0, 32'h0, 32'h0003_75D6};
    do_reset(8'h01);
    for (int f = 0; f < 8; f++) begin
      get_frame(g[f], l, r);
      checks++;
      if (l !== e[f] || r !== e[f]) begin
        errors++;
        $display("FAIL gate f%0d got %h/%h want %h", f, l, r, e[f]);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [31:0] l, r;
    logic [31:0] e [3];
    int          n;
    e = '{32'h0, 32'h0, 32'h0000_93A3};
    do_reset(8'h01);
    get_frame(8'h01, l, r);
    get_frame(8'h01, l, r);
    n = 0;
    while (!(dac_lr_clk && dac_bit_clk) && n < 3000) begin
      @(negedge MASTER_CLK);
      n++;
    end
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL mid_reset_wait got timeout want bit_clk high");
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({dac_sys_clk, dac_bit_clk, dac_lr_clk, dac_data} !== 4'b0) begin
      errors++;
      $display("FAIL mid_reset_async got %b want 0000",
               {dac_sys_clk, dac_bit_clk, dac_lr_clk, dac_data});
    end
    repeat (3) @(negedge MASTER_CLK);
    rst = 1'b0;
    for (int f = 0; f < 3; f++) begin
      get_frame(8'h01, l, r);
      checks++;
      if (l !== e[f] || r !== e[f]) begin
        errors++;
        $display("FAIL restart f%0d got %h/%h want %h", f, l, r, e[f]);
      end
    end
  endtask

`ifdef SPI_CTRL_EN
  task automatic spi_byte(input logic [7:0] b, output logic [7:0] got);
    got = '0;
    for (int i = 0; i < 8; i++) begin
      spi_mosi = b[i];
      #100;
      got[i] = spi_miso;
      spi_clk = 1'b1;
      #100;
      spi_clk = 1'b0;
    end
  endtask

  task automatic test_spi(input int nbytes, input logic [31:0] want4);
    logic [31:0] l, r;
    logic [7:0]  tx [4];
    logic [7:0]  got [4];
    tx = '{8'hD9, 8'h8E, 8'h4E, 8'h04};
    do_reset(8'h01);
    spi_cs = 1'b0;
    #100;
    for (int i = 0; i < nbytes; i++) begin
      spi_byte(tx[i], got[i]);
      if (i > 0) begin
        checks++;
        if (got[i] !== tx[i-1]) begin
          errors++;
          $display("FAIL spi_miso b%0d got %h want %h", i, got[i], tx[i-1]);
        end
      end
    end
    #100 spi_cs = 1'b1;
    for (int f = 1; f < 5; f++) begin
      get_frame(8'h01, l, r);
      if (f == 3) begin
        checks++;
        if (l !== 32'h0001_2747) begin
          errors++;
          $display("FAIL spi_f3 n%0d got %h want 00012747", nbytes, l);
        end
      end
      if (f == 4) begin
        checks++;
        if (l !== want4) begin
          errors++;
          $display("FAIL spi_f4 n%0d got %h want %h", nbytes, l, want4);
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_sawtooth();
    test_square();
    test_triangle();
    test_all_voices();
    test_gate();
    test_mid_reset();
`ifdef SPI_CTRL_EN
    test_spi(4, 32'h0002_3AEB);
    test_spi(3, 32'h0001_BAEB);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
